// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for outstanding writes with variable result latency.
// Raises the ID-stage stall on RAW/WAW hazards and lets a flushed instruction leave ID.
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 3,
  parameter int PW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_wr_en,
  input  logic [AW-1:0]   id_rd,
  input  logic [CW-1:0]   id_lat,
  input  logic            flush,
  output logic            stall,
  output logic            stall_rs,
  output logic            stall_rt,
  output logic            stall_waw,
  output logic [NREG-1:0] pend_mask,
  output logic [PW-1:0]   stall_cnt
);

  localparam int NADDR = 2 ** AW;

  logic [CW-1:0]    cnt_q [NREG];
  logic [CW-1:0]    cnt_d [NREG];
  logic [NREG-1:0]  pend_mask_q, pend_mask_d;
  logic [PW-1:0]    stall_cnt_q, stall_cnt_d;
  logic [NADDR-1:0] busy_tab;
  logic [NADDR-1:0] wr_sel;
  logic             rd_tracked;
  logic             issue;

  // Busy lookup padded to the full address space: r0 and addresses >= NREG read as idle.
  always_comb begin
    busy_tab = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_tab[i] = (cnt_q[i] != '0);
    end
  end

  assign stall_rs  = id_valid & id_use_rs & (id_rs != '0) & busy_tab[id_rs];
  assign stall_rt  = id_valid & id_use_rt & (id_rt != '0) & busy_tab[id_rt];
  assign stall_waw = id_valid & id_wr_en  & (id_rd != '0) & busy_tab[id_rd];
  assign stall     = (stall_rs | stall_rt | stall_waw) & ~flush;

  assign rd_tracked = (id_rd != '0) && (32'(id_rd) < NREG);
  assign issue      = id_valid & ~stall & ~flush & id_wr_en & rd_tracked & (id_lat != '0);

  always_comb begin
    wr_sel        = '0;
    wr_sel[id_rd] = issue;
  end

  // A new issue replaces whatever countdown the entry had this cycle.
  always_comb begin
    cnt_d[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      if (wr_sel[i]) begin
        cnt_d[i] = id_lat;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_comb begin
    pend_mask_d = '0;
    for (int i = 1; i < NREG; i++) begin
      pend_mask_d[i] = (cnt_d[i] != '0);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {PW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      pend_mask_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pend_mask_q <= pend_mask_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pend_mask = pend_mask_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic, checked against
// an absolute-time "ready at edge N" model; a PW=4 instance shares the stimulus for saturation.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs, id_use_rt, id_wr_en, flush;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [2:0]  id_lat;

  logic        stall, stall_rs, stall_rt, stall_waw;
  logic [31:0] pend_mask;
  logic [15:0] stall_cnt;
  logic        stall_s, stall_rs_s, stall_rt_s, stall_waw_s;
  logic [31:0] pend_mask_s;
  logic [3:0]  stall_cnt_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_stall = 0;
  int ready_at [32];
  logic exp_stall, exp_issue;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_lat(id_lat), .flush(flush), .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt),
    .stall_waw(stall_waw), .pend_mask(pend_mask), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.PW(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_lat(id_lat), .flush(flush), .stall(stall_s), .stall_rs(stall_rs_s), .stall_rt(stall_rt_s),
    .stall_waw(stall_waw_s), .pend_mask(pend_mask_s), .stall_cnt(stall_cnt_s)
  );

  // A register is pending while the current edge count has not reached its ready time.
  function automatic bit busy(input logic [4:0] r);
    return (r != 5'd0) && (cyc < ready_at[r]);
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt, input logic we,
                               input logic [4:0] rd, input logic [2:0] lat, input logic fl);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_wr_en = we; id_rd = rd; id_lat = lat; flush = fl;
  endtask

  task automatic checkOutput();
    logic        e_rs, e_rt, e_waw;
    logic [31:0] e_mask;
    int          e_cnt16, e_cnt4;
    e_rs      = id_valid && id_use_rs && busy(id_rs);
    e_rt      = id_valid && id_use_rt && busy(id_rt);
    e_waw     = id_valid && id_wr_en && busy(id_rd);
    exp_stall = (e_rs || e_rt || e_waw) && !flush;
    e_mask = '0;
    for (int r = 1; r < 32; r++) e_mask[r] = busy(5'(r));
    e_cnt16 = (n_stall > 65535) ? 65535 : n_stall;
    e_cnt4  = (n_stall > 15) ? 15 : n_stall;
    checkEq("stall", 32'(stall), 32'(exp_stall));
    checkEq("stall_rs", 32'(stall_rs), 32'(e_rs));
    checkEq("stall_rt", 32'(stall_rt), 32'(e_rt));
    checkEq("stall_waw", 32'(stall_waw), 32'(e_waw));
    checkEq("pend_mask", pend_mask, e_mask);
    checkEq("stall_cnt", 32'(stall_cnt), 32'(e_cnt16));
    checkEq("stall_cnt_sat", 32'(stall_cnt_s), 32'(e_cnt4));
  endtask

  // Entered and left at a falling edge; the model advances at the rising edge in between.
  task automatic runCycle(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic we,
                          input logic [4:0] rd, input logic [2:0] lat, input logic fl);
    applyStimulus(v, rs, urs, rt, urt, we, rd, lat, fl);
    #1;
    checkOutput();
    exp_issue = v && !exp_stall && !fl && we && (rd != 5'd0) && (lat != 3'd0);
    @(posedge clk);
    cyc++;
    if (exp_stall) n_stall++;
    if (exp_issue) ready_at[rd] = cyc + int'(lat);
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
    #1;
    checkOutput();
    @(posedge clk); cyc++;
    @(negedge clk); reset = 1'b1;

    // Load-use: r8 lat 2 stalls the reader for two cycles.
    runCycle(1, 5'd0, 0, 5'd0, 0, 1, 5'd8, 3'd2, 0);
    repeat (3) runCycle(1, 5'd8, 1, 5'd0, 0, 0, 5'd0, 3'd0, 0);

    // Latency 0 and r0 writes are never tracked.
    runCycle(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 3'd0, 0);
    runCycle(1, 5'd9, 1, 5'd9, 1, 0, 5'd0, 3'd0, 0);
    runCycle(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 3'd4, 0);
    runCycle(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 3'd0, 0);

    // WAW on r4: five stalled cycles, then the second write issues with lat 1.
    runCycle(1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 3'd5, 0);
    repeat (6) runCycle(1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 3'd1, 0);
    runCycle(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 3'd0, 0);

    // Flush beats a RAW stall and suppresses the write to r10.
    runCycle(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 3'd3, 0);
    runCycle(1, 5'd7, 1, 5'd0, 0, 1, 5'd10, 3'd3, 1);
    runCycle(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 3'd0, 0);

    // Same register as source and destination.
    runCycle(1, 5'd0, 0, 5'd0, 0, 1, 5'd3, 3'd4, 0);
    repeat (5) runCycle(1, 5'd3, 1, 5'd4, 1, 1, 5'd3, 3'd1, 0);

    // Repeated lat-7 producers push the 4-bit counter past saturation.
    repeat (3) begin
      runCycle(1, 5'd0, 0, 5'd0, 0, 1, 5'd2, 3'd7, 0);
      repeat (8) runCycle(1, 5'd2, 1, 5'd0, 0, 0, 5'd0, 3'd0, 0);
    end

    // Asynchronous reset in the middle of a busy r5.
    runCycle(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 3'd3, 0);
    applyStimulus(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 3'd0, 0);
    #1;
    checkOutput();
    reset = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    n_stall = 0;
    checkOutput();
    @(posedge clk); cyc++;
    @(negedge clk); reset = 1'b1;

    repeat (400) begin
      logic [4:0] rs, rt, rd;
      rs = ($urandom_range(7, 0) == 0) ? 5'($urandom_range(31, 0)) : 5'($urandom_range(7, 0));
      rt = 5'($urandom_range(7, 0));
      rd = ($urandom_range(7, 0) == 0) ? 5'($urandom_range(31, 0)) : 5'($urandom_range(7, 0));
      runCycle(1'($urandom_range(7, 0) != 0), rs, 1'($urandom_range(1, 0)), rt,
               1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) != 0), rd,
               3'($urandom_range(7, 0)), 1'($urandom_range(9, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's fixed single-cycle hazard stall logic.
- Keeps a per-register countdown scoreboard of outstanding writes with variable result latency (ALU, load, multi-cycle multiply/divide).
- Drives the ID-stage stall (HazardCtr-equivalent) for RAW and WAW hazards.
- Sits beside the IF/ID register; the decoder feeds it, and its stall output freezes the IFU and IF/ID.

Parameters:
- NREG, 32: number of architectural registers; register 0 is never tracked.
- AW, 5: register address width; must satisfy 2**AW >= NREG.
- CW, 3: countdown width; maximum latency is 2**CW-1.
- PW, 16: stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  AW  source A register.
- id_rt  in  AW  source B register.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wr_en  in  1  instruction writes a register.
- id_rd  in  AW  destination register (already muxed rt/rd/31 by decoder).
- id_lat  in  CW  cycles until result is forwardable; 0 = immediately, not tracked.
- flush  in  1  kill the ID instruction (taken branch/jump resolved).
- stall  out  1  hold IF and IF/ID this cycle (combinational).
- stall_rs  out  1  stall caused by rs.
- stall_rt  out  1  stall caused by rt.
- stall_waw  out  1  stall caused by pending destination.
- pend_mask  out  NREG  bit i = 1 when cnt[i] != 0 (registered).
- stall_cnt  out  PW  saturating count of stalled cycles.

Behaviour:
- State:
  - cnt[1..NREG-1], each CW bits.
  - stall_cnt.
  - Reset (reset == 0, async): all cnt = 0, pend_mask = 0, stall_cnt = 0.
  - Reset takes effect mid-operation immediately; stall drops to 0 combinationally because all cnt are 0.
- Per-entry FSM: IDLE (cnt == 0) / BUSY (cnt > 0).
  - BUSY: cnt decrements by 1 each clock; reaching 0 moves it to IDLE.
  - An issue write to an entry overrides that cycle's decrement.
- Hazard terms (combinational from current cnt):
  - stall_rs = id_valid & id_use_rs & (id_rs != 0) & cnt[id_rs] != 0.
  - stall_rt likewise for rt.
  - stall_waw = id_valid & id_wr_en & (id_rd != 0) & cnt[id_rd] != 0.
  - stall = (stall_rs | stall_rt | stall_waw) & ~flush. Flush overrides stall so the killed instruction leaves ID.
- Issue condition: issue = id_valid & ~stall & ~flush & id_wr_en & (id_rd != 0) & (id_lat != 0).
  - On issue, cnt[id_rd] <= id_lat at the clock edge.
- Timing example: issue at edge t with lat L.
  - A dependent instruction in ID stalls during cycles t+1 .. t+L.
  - It proceeds in cycle t+L+1.
- Register 0:
  - Never set, always reads as IDLE.
  - Writes to r0 are ignored.
  - pend_mask[0] is always 0.
- Address bounds: addresses >= NREG are treated as untracked (no stall, no issue).
- Same-instruction source and destination (e.g. add r3,r3,r4 with r3 pending): stalls on RAW; once clear, it issues normally.
- stall_cnt: increments on each cycle with stall == 1; holds at 2**PW-1.
- No other outputs are registered besides pend_mask and stall_cnt.

Test Plan:
- Reset: assert reset=0 mid-run with r5 BUSY, cnt=3 -> pend_mask=0, stall=0, stall_cnt=0 immediately, before any clock edge.
- Load-use:
  - Issue wr r8, lat=2 at edge 0; next instruction reads rs=8.
  - Required: stall=1, stall_rs=1 in cycles 1-2; stall=0 in cycle 3; stall_cnt=2.
- Latency 0 / r0:
  - Issue wr r9 lat=0, then read r9 -> no stall, pend_mask[9]=0.
  - Issue wr r0 lat=4, then read r0 -> no stall.
- WAW:
  - Issue wr r4 lat=5, then id_rd=4 lat=1 with no source use -> stall_waw=1 for 5 cycles.
  - The second instruction then issues and cnt[4] becomes 1.
- Flush priority:
  - With r7 pending cnt=3, ID reads r7 and flush=1 -> stall=0, no issue.
  - stall_cnt does not increment that cycle.
- Saturation: PW=4, hold a dependent instruction for 20 cycles behind a repeatedly re-issued lat=7 write -> stall_cnt stops at 15.
